// File: rtl/row_readout_serializer_if.sv
// Byte-stream beat interface for one row readout: valid/ready handshake plus
// data, position index and start/end-of-row markers.
interface row_readout_serializer_if #(
    parameter int NUM_PIXELS = 10,
    parameter int IDX_W      = $clog2(NUM_PIXELS + 1)
);
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_sof;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_sof,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_sof,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/row_readout_serializer.sv
// Snapshots one row of ADC pixel codes on row_done and streams header + pixels
// one byte per beat. Define ROW_CHECKSUM_EN to append an XOR checksum beat.
module row_readout_serializer #(
    parameter int NUM_PIXELS = 10,
    localparam int IDX_W     = $clog2(NUM_PIXELS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       row_done,
    input  logic [NUM_PIXELS-1:0][7:0] pixel_values,
    input  logic [7:0]                 row_id,
    row_readout_serializer_if.master   out_if,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       clr_ovr
);

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_PIXELS - 1);

`ifdef ROW_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HEADER, PIXEL, CKSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PIXEL} state_t;
`endif

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic [NUM_PIXELS-1:0][7:0]  snap_q, snap_d;
    logic [7:0]                  id_q, id_d;
    logic                        overrun_q, overrun_d;

    logic                        out_valid_q, out_valid_d;
    logic [7:0]                  out_data_q, out_data_d;
    logic [IDX_W-1:0]            out_index_q, out_index_d;
    logic                        out_sof_q, out_sof_d;
    logic                        out_last_q, out_last_d;

    logic                        fire;
    logic                        final_fire;
    logic [7:0]                  pix_sel;

`ifdef ROW_CHECKSUM_EN
    logic [7:0]                  cksum;

    always_comb begin
        cksum = id_q;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            cksum = cksum ^ snap_q[i];
        end
    end
`endif

    assign fire = out_valid_q & out_if.out_ready;

    // Next-state logic; a row_done on the final handshake reloads straight into HEADER.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        snap_d     = snap_q;
        id_d       = id_q;
        overrun_d  = overrun_q;
        final_fire = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            HEADER: begin
                if (fire) begin
                    ptr_d   = '0;
                    state_d = PIXEL;
                end
            end
            PIXEL: begin
                if (fire) begin
                    if (ptr_q == LAST_PTR) begin
`ifdef ROW_CHECKSUM_EN
                        state_d = CKSUM;
`else
                        final_fire = 1'b1;
                        state_d    = IDLE;
`endif
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
`ifdef ROW_CHECKSUM_EN
            CKSUM: begin
                if (fire) begin
                    final_fire = 1'b1;
                    state_d    = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (row_done && ((state_q == IDLE) || final_fire)) begin
            snap_d  = pixel_values;
            id_d    = row_id;
            ptr_d   = '0;
            state_d = HEADER;
        end

        if (row_done && (state_q != IDLE) && !final_fire) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        pix_sel = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (ptr_d == IDX_W'(i)) begin
                pix_sel = snap_d[i];
            end
        end
    end

    // Beat outputs are decoded from the next state so they leave a flop each cycle.
    always_comb begin
        out_valid_d = (state_d != IDLE);
        out_data_d  = '0;
        out_index_d = '0;
        out_sof_d   = 1'b0;
        out_last_d  = 1'b0;

        case (state_d)
            HEADER: begin
                out_data_d = id_d;
                out_sof_d  = 1'b1;
            end
            PIXEL: begin
                out_data_d  = pix_sel;
                out_index_d = ptr_d;
`ifndef ROW_CHECKSUM_EN
                out_last_d  = (ptr_d == LAST_PTR);
`endif
            end
`ifdef ROW_CHECKSUM_EN
            CKSUM: begin
                out_data_d  = cksum;
                out_index_d = IDX_W'(NUM_PIXELS);
                out_last_d  = 1'b1;
            end
`endif
            default: begin
                out_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            snap_q      <= '0;
            id_q        <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            snap_q      <= snap_d;
            id_q        <= id_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_sof_q   <= out_sof_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_index = out_index_q;
    assign out_if.out_sof   = out_sof_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = (state_q != IDLE);
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_row_readout_serializer.sv
// Bench for row_readout_serializer: directed scenarios then random traffic,
// checked against a beat-queue model of each row's expected stream.
module tb_row_readout_serializer;

    localparam int NP = 10;
    localparam int IW = $clog2(NP + 1);

    typedef logic [NP-1:0][7:0] pix_t;

    typedef struct {
        logic [7:0] data;
        int         idx;
        bit         sof;
        bit         last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       row_done;
    pix_t       pixel_values;
    logic [7:0] row_id;
    logic       busy;
    logic       overrun;
    logic       clr_ovr;

    beat_t      exp_q[$];
    bit         exp_ovr;
    int         checks;
    int         passed;

    row_readout_serializer_if #(.NUM_PIXELS(NP)) bus ();

    row_readout_serializer #(.NUM_PIXELS(NP)) dut (
        .clk          (clk),
        .reset        (reset),
        .row_done     (row_done),
        .pixel_values (pixel_values),
        .row_id       (row_id),
        .out_if       (bus),
        .busy         (busy),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        $error("[TB] FAIL %s observed=timeout expected=condition_reached", tag);
    endtask

    function automatic pix_t rampPix();
        pix_t p;
        for (int i = 0; i < NP; i++) p[i] = 8'(10 * i + 5);
        return p;
    endfunction

    function automatic pix_t randPix();
        pix_t p;
        for (int i = 0; i < NP; i++) p[i] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    // Expected stream for one row: header, every pixel, optional XOR checksum.
    function automatic void pushRow(input logic [7:0] id, input pix_t pix);
        logic [7:0] x;
        beat_t b;
        b.data = id; b.idx = 0; b.sof = 1'b1; b.last = 1'b0;
        exp_q.push_back(b);
        x = id;
        for (int i = 0; i < NP; i++) begin
            b.data = pix[i]; b.idx = i; b.sof = 1'b0;
`ifdef ROW_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NP - 1);
`endif
            exp_q.push_back(b);
            x = x ^ pix[i];
        end
`ifdef ROW_CHECKSUM_EN
        b.data = x; b.idx = NP; b.sof = 1'b0; b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic applyStimulus(input bit rd, input logic [7:0] id, input pix_t pix,
                                 input bit rdy, input bit clr, input bit rst);
        bit was_busy;
        bit fire;
        bit fin;
        row_done         = rd;
        row_id           = id;
        pixel_values     = pix;
        bus.out_ready    = rdy;
        clr_ovr          = clr;
        reset            = rst;

        was_busy = (exp_q.size() > 0);
        checkOutput("out_valid", 32'(bus.out_valid), 32'(was_busy));
        checkOutput("busy", 32'(busy), 32'(was_busy));
        checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
        if (was_busy) begin
            checkOutput("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
            checkOutput("out_index", 32'(bus.out_index), 32'(exp_q[0].idx));
            checkOutput("out_sof", 32'(bus.out_sof), 32'(exp_q[0].sof));
            checkOutput("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
        end else begin
            checkOutput("idle_sof", 32'(bus.out_sof), 32'(0));
            checkOutput("idle_last", 32'(bus.out_last), 32'(0));
        end

        if (rst) begin
            exp_q.delete();
            exp_ovr = 1'b0;
        end else begin
            fire = was_busy && rdy;
            fin  = fire && (exp_q.size() == 1);
            if (fire) void'(exp_q.pop_front());
            if (rd && (!was_busy || fin)) pushRow(id, pix);
            if (rd && was_busy && !fin) exp_ovr = 1'b1;
            else if (clr) exp_ovr = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drainIdle(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            applyStimulus(1'b0, 8'($urandom), randPix(), 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (exp_q.size() > 0) reportTimeout(tag);
        applyStimulus(1'b0, 8'($urandom), randPix(), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        bit r;
        checks           = 0;
        passed           = 0;
        exp_ovr          = 1'b0;
        reset            = 1'b1;
        row_done         = 1'b0;
        row_id           = '0;
        pixel_values     = '0;
        clr_ovr          = 1'b0;
        bus.out_ready    = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_valid", 32'(bus.out_valid), 32'(0));
        checkOutput("rst_data", 32'(bus.out_data), 32'(0));
        checkOutput("rst_index", 32'(bus.out_index), 32'(0));
        checkOutput("rst_sof", 32'(bus.out_sof), 32'(0));
        checkOutput("rst_last", 32'(bus.out_last), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_overrun", 32'(overrun), 32'(0));
        $display("[TB] reset checks done");

        applyStimulus(1'b1, 8'h3C, rampPix(), 1'b1, 1'b0, 1'b0);
        drainIdle("normal_row");

        applyStimulus(1'b1, 8'h3C, rampPix(), 1'b0, 1'b0, 1'b0);
        r = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            r = ~r;
            applyStimulus(1'b0, 8'($urandom), randPix(), r, 1'b0, 1'b0);
            n++;
        end
        if (exp_q.size() > 0) reportTimeout("backpressure");
        applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 8'h3C, rampPix(), 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!(exp_q.size() > 0 && !exp_q[0].sof && exp_q[0].idx == 4) && n < 50) begin
            applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!(exp_q.size() > 0 && exp_q[0].idx == 4)) reportTimeout("overrun_wait");
        applyStimulus(1'b1, 8'h01, randPix(), 1'b1, 1'b0, 1'b0);
        drainIdle("overrun_row");
        applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 8'h3C, rampPix(), 1'b1, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() != 1 && n < 50) begin
            applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (exp_q.size() != 1) reportTimeout("restart_wait");
        applyStimulus(1'b1, 8'h7F, randPix(), 1'b1, 1'b0, 1'b0);
        drainIdle("restart_row");

        applyStimulus(1'b1, 8'h3C, rampPix(), 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!(exp_q.size() > 0 && !exp_q[0].sof && exp_q[0].idx == 5) && n < 50) begin
            applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (!(exp_q.size() > 0 && exp_q[0].idx == 5)) reportTimeout("reset_wait");
        applyStimulus(1'b0, 8'h00, randPix(), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, randPix(), 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, randPix(), 1'b1, 1'b0, 1'b0);
        drainIdle("after_reset_row");

        for (int c = 0; c < 800; c++) begin
            applyStimulus($urandom_range(0, 7) == 0, 8'($urandom), randPix(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'b0);
        end
        drainIdle("random_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/row_readout_serializer.md
Name: row_readout_serializer

Overview:
Reader side of the per-row ADC capture registers. On a row-done pulse it snapshots the row's NUM_PIXELS 8-bit conversion results and a row ID. It then streams them out one byte per beat over a valid/ready interface: a header beat, then pixel 0..NUM_PIXELS-1. It sits between the single-slope row ADC capture logic and the downstream frame packer / trace logger.

Parameters:
NUM_PIXELS, 10, number of pixel values per row (>=2)
IDX_W, $clog2(NUM_PIXELS+1), width of out_index (derived; not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
row_done  in  1  single-cycle pulse: pixel_values and row_id valid and stable this cycle
pixel_values  in  NUM_PIXELS x 8 (packed [NUM_PIXELS-1:0][7:0])  captured counter codes, index i = pixel i
row_id  in  8  row number, sent in the header beat
out_valid  out  1  beat available
out_ready  in  1  downstream accepts beat when out_valid & out_ready
out_data  out  8  header: row_id; pixel beat: snapshot value
out_index  out  IDX_W  header: 0; pixel i: i
out_sof  out  1  high on the header beat only
out_last  out  1  high on the final beat of the row
busy  out  1  high while a row is held or streaming
overrun  out  1  sticky: row_done arrived while busy
clr_ovr  in  1  clears overrun

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out_valid, out_sof, out_last, busy, overrun = 0; out_data = 0; out_index = 0; snapshot registers and pointer = 0. Reset asserted mid-stream abandons the row; nothing is sent after the reset cycle.
- FSM states: IDLE, HEADER, PIXEL (plus CKSUM, see optional feature). busy = (state != IDLE).
- IDLE: if row_done, latch all pixel_values and row_id into the snapshot and go to HEADER. The header is presented the cycle after row_done (1-cycle latency).
- HEADER: out_valid=1, out_sof=1, out_data=row_id snapshot, out_index=0. On handshake, ptr=0 and go to PIXEL.
- PIXEL: out_valid=1, out_data=snap[ptr], out_index=ptr, out_last=(ptr==NUM_PIXELS-1).
  - On handshake, ptr++.
  - On handshake at ptr==NUM_PIXELS-1, go to IDLE.
- Handshake: a beat transfers on the rising edge where out_valid & out_ready.
  - While out_valid & !out_ready, all out_* are held stable.
  - out_valid never drops without a transfer, except on reset.
  - Back-to-back beats run at 1 per cycle when out_ready is held high.
- row_done while busy, not coincident with the final handshake: ignored, snapshot unchanged, overrun<=1 at the next edge.
- row_done in the same cycle as the final-beat handshake: accepted. Snapshot is loaded and the next state is HEADER (no idle bubble). overrun is not set.
- clr_ovr: overrun<=0. If a new overrun event and clr_ovr occur in the same cycle, set wins.
- Outputs are registered, with no combinational path from out_ready to out_valid.
- pixel_values is sampled only on an accepted row_done; changes at other times have no effect.

Optional Feature:
ROW_CHECKSUM_EN
- Defined: after pixel NUM_PIXELS-1, one extra CKSUM beat is sent.
  - out_data = XOR of the row_id snapshot and all NUM_PIXELS snapshot values.
  - out_index = NUM_PIXELS, out_last=1 on this beat only; the last pixel beat has out_last=0.
  - The "final handshake" in the coincident-row_done rule is the CKSUM beat.
- Undefined: no CKSUM state; behaviour as above. Beats per row = NUM_PIXELS+1.

Test Plan:
1. Reset check: assert reset for 2 cycles with out_ready=1 and row_done=0 → all outputs 0, busy=0, overrun=0.
2. Normal row, ready held high: row_id=0x3C, pixel i = 10*i+5, row_done pulse at cycle T → 11 consecutive beats T+1..T+11.
   - Header 0x3C with sof=1, index 0.
   - Then 0x05,0x0F,...,0x5F at indices 0..9, last=1 only at index 9.
   - busy=0 at T+12.
   - With ROW_CHECKSUM_EN: 12th beat 0x16, index 10, last=1.
3. Backpressure: same row, out_ready toggles 0,1,0,1,... → each beat held stable while not ready; exactly 11 transfers, values in order, none duplicated or dropped.
4. Overrun: second row_done (row_id 0x01) during pixel beat 4 → overrun=1 next cycle, remaining beats still from row 0x3C; clr_ovr pulse → overrun=0.
5. Coincident restart: row_done (row_id 0x7F) in the same cycle as the index-9 handshake → header 0x7F valid the next cycle, overrun stays 0.
6. Mid-stream reset: reset after pixel 4 is accepted → out_valid=0 the following cycle and busy=0. A new row_done then restarts with a header; old data never appears.
